cont4bits_down: RTL and testbench
=================================

CONT4BITS_DOWN -- requirements
Module: cont4bits_down

Interface
REQ-001 Parameter: WIDTH, default 4, counter and load-data width in bits.
REQ-002 Port: clk  input  1  system clock, rising-edge active, single clock domain.
REQ-003 Port: reset_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: load  input  1  when 1 at a clk edge, din is captured as the start value.
REQ-005 Port: din  input  WIDTH  start value, sampled only when load=1.
REQ-006 Port: enable  input  1  count-step qualifier, sampled at each clk edge.
REQ-007 Port: Q  output  WIDTH  current count, registered.
REQ-008 Port: TC  output  1  terminal count (zero reached), combinational from Q.
REQ-009 Port: busy  output  1  high while state is RUN, registered via state.

Function
REQ-010 The block SHALL implement a 3-state FSM: IDLE, RUN, EXPIRED.
REQ-011 TC SHALL equal (Q == 0), independent of enable and state.
REQ-012 busy SHALL equal 1 iff state == RUN.
REQ-013 load SHALL have priority over enable in every state.
REQ-014 load=1, din!=0: Q<=din, reload register<=din, next state RUN, at that edge.
REQ-015 load=1, din==0: Q<=0, reload register<=0, next state EXPIRED.
REQ-016 IDLE, load=0: Q holds; enable is ignored.
REQ-017 RUN, load=0, enable=1, Q>1: Q<=Q-1, state stays RUN.
REQ-018 RUN, load=0, enable=1, Q==1: Q<=0, next state EXPIRED; TC rises the same cycle Q becomes 0.
REQ-019 RUN, load=0, enable=0: Q and state hold.
REQ-020 Q SHALL never wrap from 0 to all-ones; decrement below 0 is impossible.
REQ-021 EXPIRED, load=0: behaviour per REQ-026/REQ-027.
REQ-022 Latency: load to Q valid is 1 clk edge; enable to Q update is 1 clk edge.

Reset
REQ-023 reset_n=0 SHALL immediately force Q=0, reload register=0, state=IDLE, independent of clk.
REQ-024 During and after reset: Q=0, TC=1, busy=0.
REQ-025 Reset asserted mid-count SHALL abort the count; no further decrements until a new load.

Configuration
REQ-026 With AUTO_RELOAD_EN defined: in EXPIRED with enable=1 and reload register!=0, Q<=reload register and next state RUN; with reload register==0, stays EXPIRED.
REQ-027 Without AUTO_RELOAD_EN: EXPIRED holds Q=0 until load or reset; enable is ignored; reload register may be omitted.

Structure
REQ-028 A shared package SHALL hold the FSM state typedef (IDLE, RUN, EXPIRED) and the default WIDTH constant.
REQ-029 No sub-module is required; FSM, reload register and counter datapath reside in one module.

Verification
REQ-030 Reset: assert reset_n=0 mid-clock -> Q=0, TC=1, busy=0 without waiting for an edge.
REQ-031 Load din=4'd3, then enable=1 for 3 cycles -> Q=3,2,1,0; busy 1,1,1,0; TC=1 only when Q=0; state EXPIRED.
REQ-032 Load din=4'd5, enable toggling 1,0,1 -> Q=5,4,4,3; state RUN throughout.
REQ-033 Load and enable both 1 while Q=2 in RUN, din=4'd9 -> Q=9, enable ignored that cycle.
REQ-034 Load din=4'd0 -> Q=0, TC=1, busy=0, state EXPIRED; enable=1 with AUTO_RELOAD_EN -> stays EXPIRED.
REQ-035 Load din=4'd2, count to 0, hold enable=1 -> with AUTO_RELOAD_EN: Q=2,1,0,2,1,0; without: Q stays 0.

Source files
------------

// File: rtl/cont4bits_down_pkg.sv
// Shared types and constants for the cont4bits_down loadable down-counter.
package cont4bits_down_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

endpackage

// File: rtl/cont4bits_down.sv
// Loadable down-counter with IDLE/RUN/EXPIRED control FSM that stops at zero.
// Define AUTO_RELOAD_EN to restart from the last loaded value when enabled in EXPIRED.
module cont4bits_down
  import cont4bits_down_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             enable,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             busy,
  output state_t           state
);

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;

`ifdef AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) reload_q <= ZERO;
    else          reload_q <= reload_d;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      count_q <= ZERO;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // load wins in every state; a zero load goes straight to EXPIRED.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
`ifdef AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    if (load) begin
      count_d = din;
`ifdef AUTO_RELOAD_EN
      reload_d = din;
`endif
      state_d = (din == ZERO) ? EXPIRED : RUN;
    end else begin
      unique case (state_q)
        IDLE: ;
        RUN: begin
          if (enable) begin
            if (count_q > ONE) begin
              count_d = count_q - ONE;
            end else begin
              count_d = ZERO;
              state_d = EXPIRED;
            end
          end
        end
        EXPIRED: begin
`ifdef AUTO_RELOAD_EN
          if (enable && (reload_q != ZERO)) begin
            count_d = reload_q;
            state_d = RUN;
          end
`endif
        end
        default: begin
          state_d = IDLE;
          count_d = ZERO;
        end
      endcase
    end
  end

  assign Q     = count_q;
  assign TC    = (count_q == ZERO);
  assign busy  = (state_q == RUN);
  assign state = state_q;

endmodule

// File: tb/tb_cont4bits_down.sv
// Directed self-checking bench for cont4bits_down; expectations track AUTO_RELOAD_EN.
module tb_cont4bits_down;
  import cont4bits_down_pkg::*;

  logic       clk;
  logic       reset_n;
  logic       load;
  logic [3:0] din;
  logic       enable;
  logic [3:0] q;
  logic       tc;
  logic       busy;
  state_t     state;

  int checks   = 0;
  int failures = 0;

  cont4bits_down #(.WIDTH(4)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (load),
    .din    (din),
    .enable (enable),
    .Q      (q),
    .TC     (tc),
    .busy   (busy),
    .state  (state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] eq, input logic etc,
                         input logic ebusy, input state_t est);
    chk({tag, ".Q"},     32'(q),     32'(eq));
    chk({tag, ".TC"},    32'(tc),    32'(etc));
    chk({tag, ".busy"},  32'(busy),  32'(ebusy));
    chk({tag, ".state"}, 32'(state), 32'(est));
  endtask

  initial begin
    reset_n = 1'b1;
    load    = 1'b0;
    din     = 4'd0;
    enable  = 1'b0;

    // asynchronous reset, checked before any clock edge
    #2 reset_n = 1'b0;
    #1 chk_all("reset_async", 4'd0, 1'b1, 1'b0, IDLE);
    step();
    step();
    chk_all("reset_held", 4'd0, 1'b1, 1'b0, IDLE);
    @(negedge clk) reset_n = 1'b1;

    // IDLE ignores enable
    enable = 1'b1;
    step();
    chk_all("idle_enable", 4'd0, 1'b1, 1'b0, IDLE);

    // load 3 and count to zero
    load = 1'b1; din = 4'd3; enable = 1'b0;
    step();
    chk_all("load3", 4'd3, 1'b0, 1'b1, RUN);
    load = 1'b0; enable = 1'b1;
    step();
    chk_all("cnt2", 4'd2, 1'b0, 1'b1, RUN);
    step();
    chk_all("cnt1", 4'd1, 1'b0, 1'b1, RUN);
    step();
    chk_all("cnt0", 4'd0, 1'b1, 1'b0, EXPIRED);
    enable = 1'b0;
    step();
    chk_all("expired_hold", 4'd0, 1'b1, 1'b0, EXPIRED);

    // load 5 with enable toggling
    load = 1'b1; din = 4'd5;
    step();
    chk_all("load5", 4'd5, 1'b0, 1'b1, RUN);
    load = 1'b0; enable = 1'b1;
    step();
    chk_all("tog_en1", 4'd4, 1'b0, 1'b1, RUN);
    enable = 1'b0;
    step();
    chk_all("tog_en0", 4'd4, 1'b0, 1'b1, RUN);
    enable = 1'b1;
    step();
    chk_all("tog_en1b", 4'd3, 1'b0, 1'b1, RUN);
    step();
    chk_all("cnt_to2", 4'd2, 1'b0, 1'b1, RUN);

    // load has priority over enable
    load = 1'b1; din = 4'd9;
    step();
    chk_all("load_prio", 4'd9, 1'b0, 1'b1, RUN);
    load = 1'b0;
    step();
    chk_all("after_prio", 4'd8, 1'b0, 1'b1, RUN);

    // reset mid-count aborts the count
    #2 reset_n = 1'b0;
    #1 chk_all("reset_mid", 4'd0, 1'b1, 1'b0, IDLE);
    @(negedge clk) reset_n = 1'b1;
    step();
    chk_all("post_reset_idle", 4'd0, 1'b1, 1'b0, IDLE);

    // zero load goes straight to EXPIRED and stays there
    load = 1'b1; din = 4'd0;
    step();
    chk_all("load0", 4'd0, 1'b1, 1'b0, EXPIRED);
    load = 1'b0; enable = 1'b1;
    step();
    chk_all("load0_en", 4'd0, 1'b1, 1'b0, EXPIRED);

    // load 2, hold enable through expiry
    load = 1'b1; din = 4'd2;
    step();
    chk_all("load2", 4'd2, 1'b0, 1'b1, RUN);
    load = 1'b0;
    step();
    chk_all("l2_cnt1", 4'd1, 1'b0, 1'b1, RUN);
    step();
    chk_all("l2_cnt0", 4'd0, 1'b1, 1'b0, EXPIRED);
    step();
`ifdef AUTO_RELOAD_EN
    chk_all("l2_reload", 4'd2, 1'b0, 1'b1, RUN);
    step();
    chk_all("l2_rl_cnt1", 4'd1, 1'b0, 1'b1, RUN);
    step();
    chk_all("l2_rl_cnt0", 4'd0, 1'b1, 1'b0, EXPIRED);
`else
    chk_all("l2_stay0", 4'd0, 1'b1, 1'b0, EXPIRED);
    step();
    chk_all("l2_stay0b", 4'd0, 1'b1, 1'b0, EXPIRED);
    step();
    chk_all("l2_stay0c", 4'd0, 1'b1, 1'b0, EXPIRED);
`endif

    // full-scale load, then hold with enable low
    load = 1'b1; din = 4'd15; enable = 1'b0;
    step();
    chk_all("load15", 4'd15, 1'b0, 1'b1, RUN);
    load = 1'b0;
    step();
    chk_all("hold15", 4'd15, 1'b0, 1'b1, RUN);
    enable = 1'b1;
    step();
    chk_all("cnt14", 4'd14, 1'b0, 1'b1, RUN);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
